inc_reg_bank: RTL and testbench
===============================

# inc_reg_bank

Parametrised bank of address/state counters for the datapath: holds NREG independent WIDTH-bit registers (row, column, current, state pointers A/B/C, R1 in the default build) and increments any subset of them in a single cycle from a bitmask select. Adds what the plain increment decoder lacks:
- registered storage with parallel load and clear;
- per-register wrap-or-saturate mode;
- sticky overflow flags.

It sits between the control unit (which drives select/enable) and the datapath (which reads the counter values and the overflow flags).

## Interface
- NREG, 7, number of counter registers (1..16)
- WIDTH, 8, bits per register (2..32)
- SAT_MASK, 0, NREG-bit mask; bit i=1 makes register i saturate at all-ones, 0 makes it wrap to 0
- STEP_W, 2, width of the increment step input

Ports (reset is asynchronous and active-low):
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- inc_en  in  1  global increment enable
- inc_sel  in  NREG  increment bitmask, bit i selects register i; any number of bits may be set
- inc_step  in  STEP_W  unsigned increment amount applied to every selected register; 0 means no change
- ld_en  in  1  parallel load strobe
- ld_idx  in  clog2(NREG)  register index to load
- ld_data  in  WIDTH  load value
- clr_sel  in  NREG  synchronous clear bitmask
- ovf_clr  in  NREG  clears sticky overflow flags (bitmask)
- q  out  NREG*WIDTH  register values, register i at bits [i*WIDTH +: WIDTH]
- ovf  out  NREG  sticky overflow flag per register
- inc_ack  out  1  pulses high the cycle after any increment was applied

## Operation
- Per register i, per rising edge, exactly one action is taken, in priority order:
  - clear: if clr_sel[i]=1, register i becomes 0;
  - load: else if ld_en=1 and ld_idx=i, register i becomes ld_data;
  - increment: else if inc_en=1 and inc_sel[i]=1, register i takes the increment result below;
  - hold: otherwise register i keeps its value.
- Increment arithmetic uses WIDTH+1 bits: sum = q_i + zero-extended inc_step.
  - If sum[WIDTH]=1 and SAT_MASK[i]=0: q_i = sum[WIDTH-1:0] (wrap modulo 2^WIDTH).
  - If sum[WIDTH]=1 and SAT_MASK[i]=1: q_i = all-ones.
  - In either mode, a carry-out sets ovf[i].
  - Without a carry-out, q_i = sum[WIDTH-1:0].
- ld_idx ≥ NREG: the load is ignored; no register changes because of it.
- ovf[i] behaviour:
  - Set by an increment overflow on register i.
  - Cleared by ovf_clr[i] only when no overflow occurs on register i in the same cycle; a simultaneous set wins over the clear.
  - Clear and load of register i do not affect ovf[i].
- inc_ack registers (inc_en && (inc_sel masked by "not cleared, not loaded") != 0 && inc_step != 0).
- The increment select is treated as an unencoded bitmask. The control unit's one-hot encodings pass through unchanged, and multi-hot selections are legal.

## Timing
- Asynchronous reset: q=0, ovf=0, inc_ack=0 immediately on rst_n falling, independent of clk. Asserting reset mid-operation discards any pending edge action.
- On reset release, the first rising edge with rst_n=1 performs normal actions.
- Latency: every action is visible on q and ovf one cycle after the edge that samples the controls. No combinational path from any input to any output.
- Unselected registers never change. No enable means no toggling; q is stable between edges.
- inc_ack is high for exactly one cycle per qualifying edge; back-to-back increments keep it high continuously.
- Outputs are registered.

## Test plan
- Reset and defaults: drive rst_n=0 asynchronously mid-cycle → q all 0, ovf 0, inc_ack 0 before the next edge. After release, hold all controls 0 for 10 cycles → q unchanged.
- Multi-hot increment (NREG=7, WIDTH=8): inc_sel=7'b1010101, inc_step=1, for 3 cycles → registers 0,2,4,6 = 3, others 0; inc_ack high 3 cycles, starting one cycle late.
- Wrap vs saturate (SAT_MASK=7'b0000010): load reg0=reg1=8'hFE, then increment both with step=3 → reg0=8'h01, reg1=8'hFF, ovf=7'b0000011.
- Priority conflict on reg2: clr_sel[2]=1, ld_en=1 with ld_idx=2 and ld_data=8'h55, inc_sel[2]=1, all in one cycle → reg2=0. Next cycle with load plus increment only → reg2=8'h55, inc_ack=0.
- Sticky flag: overflow reg3, then ovf_clr[3]=1 on a cycle that overflows reg3 again → ovf[3] stays 1. A later ovf_clr[3]=1 alone → ovf[3]=0.
- Edge cases: ld_idx=7 with NREG=7 → no change. inc_step=0 with inc_en=1 → q unchanged, inc_ack=0.

Source files
------------

// File: rtl/inc_reg_bank.sv
// Bank of NREG independent WIDTH-bit counters with multi-hot increment, parallel
// load, clear, per-register wrap/saturate and sticky overflow flags.
module inc_reg_bank #(
    parameter int              NREG     = 7,
    parameter int              WIDTH    = 8,
    parameter logic [NREG-1:0] SAT_MASK = '0,
    parameter int              STEP_W   = 2,
    localparam int             IDX_W    = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inc_en,
    input  logic [NREG-1:0]       inc_sel,
    input  logic [STEP_W-1:0]     inc_step,
    input  logic                  ld_en,
    input  logic [IDX_W-1:0]      ld_idx,
    input  logic [WIDTH-1:0]      ld_data,
    input  logic [NREG-1:0]       clr_sel,
    input  logic [NREG-1:0]       ovf_clr,
    output logic [NREG*WIDTH-1:0] q,
    output logic [NREG-1:0]       ovf,
    output logic                  inc_ack
);

    logic [NREG-1:0][WIDTH-1:0] q_q, q_d;
    logic [NREG-1:0]            ovf_q, ovf_d, ovf_set;
    logic                       ack_q, ack_d;

    // Returns {carry, next value}; saturating registers pin at all-ones on carry.
    function automatic logic [WIDTH:0] inc_sat(input logic [WIDTH-1:0]  cur,
                                               input logic [STEP_W-1:0] step,
                                               input logic              sat);
        logic [WIDTH:0] sum;
        sum = {1'b0, cur} + (WIDTH+1)'(step);
        if (sum[WIDTH] && sat) begin
            return {1'b1, {WIDTH{1'b1}}};
        end
        return sum;
    endfunction

    always_comb begin
        logic [WIDTH:0] inc_res;
        logic           ld_hit;
        q_d     = q_q;
        ovf_set = '0;
        ack_d   = 1'b0;
        inc_res = '0;
        ld_hit  = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            ld_hit = ld_en && (ld_idx == IDX_W'(i));
            if (clr_sel[i]) begin
                q_d[i] = '0;
            end else if (ld_hit) begin
                q_d[i] = ld_data;
            end else if (inc_en && inc_sel[i]) begin
                inc_res    = inc_sat(q_q[i], inc_step, SAT_MASK[i]);
                q_d[i]     = inc_res[WIDTH-1:0];
                ovf_set[i] = inc_res[WIDTH];
                if (inc_step != '0) begin
                    ack_d = 1'b1;
                end
            end
        end
        // A fresh overflow beats a simultaneous flag clear.
        ovf_d = (ovf_q & ~ovf_clr) | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= '0;
            ovf_q <= '0;
            ack_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
            ack_q <= ack_d;
        end
    end

    assign q       = q_q;
    assign ovf     = ovf_q;
    assign inc_ack = ack_q;

endmodule

// File: tb/tb_inc_reg_bank.sv
// Scoreboard bench for inc_reg_bank (NREG=7, WIDTH=8, SAT_MASK=7'b0000010):
// the driver queues hand-computed expectations, a monitor checks each cycle.
module tb_inc_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inc_en = 1'b0;
    logic [6:0]  inc_sel = '0;
    logic [1:0]  inc_step = '0;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_idx = '0;
    logic [7:0]  ld_data = '0;
    logic [6:0]  clr_sel = '0;
    logic [6:0]  ovf_clr = '0;
    logic [55:0] q;
    logic [6:0]  ovf;
    logic        inc_ack;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [55:0] eq;
        logic [6:0]  eo;
        logic        ea;
        string       nm;
    } exp_t;

    exp_t sb[$];

    inc_reg_bank #(
        .NREG(7), .WIDTH(8), .SAT_MASK(7'b0000010), .STEP_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .inc_en(inc_en), .inc_sel(inc_sel), .inc_step(inc_step),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .clr_sel(clr_sel), .ovf_clr(ovf_clr),
        .q(q), .ovf(ovf), .inc_ack(inc_ack)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [55:0] act, input logic [55:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endfunction

    task automatic drive(input logic ie, input logic [6:0] isel, input logic [1:0] istep,
                         input logic le, input logic [2:0] lidx, input logic [7:0] ldat,
                         input logic [6:0] csel, input logic [6:0] oclr,
                         input logic [55:0] eq, input logic [6:0] eo, input logic ea,
                         input string nm);
        exp_t e;
        @(negedge clk);
        inc_en = ie; inc_sel = isel; inc_step = istep;
        ld_en = le; ld_idx = lidx; ld_data = ldat;
        clr_sel = csel; ovf_clr = oclr;
        e.eq = eq; e.eo = eo; e.ea = ea; e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic idle(input logic [55:0] eq, input logic [6:0] eo, input string nm);
        drive(0, 7'h00, 2'd0, 0, 3'd0, 8'h00, 7'h00, 7'h00, eq, eo, 0, nm);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.nm, ".q"},   q,                e.eq);
                check({e.nm, ".ovf"}, {49'b0, ovf},     {49'b0, e.eo});
                check({e.nm, ".ack"}, {55'b0, inc_ack}, {55'b0, e.ea});
            end
        end
    end

    initial begin : stim
        int guard;
        #12 rst_n = 1'b1;

        // Make state non-zero, then reset asynchronously mid-cycle.
        drive(0, 7'h00, 2'd0, 1, 3'd0, 8'hAA, 7'h00, 7'h00, 56'h00_00_00_00_00_00_AA, 7'h00, 0, "load_pre_reset");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        inc_en = 0; ld_en = 0; inc_sel = '0; clr_sel = '0; ovf_clr = '0;
        #1;
        check("async_rst.q",   q,                56'h0);
        check("async_rst.ovf", {49'b0, ovf},     56'h0);
        check("async_rst.ack", {55'b0, inc_ack}, 56'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) idle(56'h0, 7'h00, "idle_hold");

        // Multi-hot increment on 0,2,4,6.
        drive(1, 7'b1010101, 2'd1, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h01_00_01_00_01_00_01, 7'h00, 1, "multihot1");
        drive(1, 7'b1010101, 2'd1, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h02_00_02_00_02_00_02, 7'h00, 1, "multihot2");
        drive(1, 7'b1010101, 2'd1, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h03_00_03_00_03_00_03, 7'h00, 1, "multihot3");
        idle(56'h03_00_03_00_03_00_03, 7'h00, "multihot_idle");

        // Wrap (reg0) versus saturate (reg1).
        drive(0, 7'h00, 2'd0, 1, 3'd0, 8'hFE, 7'h00, 7'h00, 56'h03_00_03_00_03_00_FE, 7'h00, 0, "load_r0");
        drive(0, 7'h00, 2'd0, 1, 3'd1, 8'hFE, 7'h00, 7'h00, 56'h03_00_03_00_03_FE_FE, 7'h00, 0, "load_r1");
        drive(1, 7'b0000011, 2'd3, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h03_00_03_00_03_FF_01, 7'b0000011, 1, "wrap_sat");

        // Priority: clear beats load beats increment.
        drive(1, 7'b0000100, 2'd1, 1, 3'd2, 8'h55, 7'b0000100, 7'h00, 56'h03_00_03_00_00_FF_01, 7'b0000011, 0, "prio_clr");
        drive(1, 7'b0000100, 2'd1, 1, 3'd2, 8'h55, 7'h00, 7'h00, 56'h03_00_03_00_55_FF_01, 7'b0000011, 0, "prio_ld");

        // Sticky overflow on reg3; load must not disturb the flag.
        drive(0, 7'h00, 2'd0, 1, 3'd3, 8'hFF, 7'h00, 7'h00, 56'h03_00_03_FF_55_FF_01, 7'b0000011, 0, "load_r3");
        drive(1, 7'b0001000, 2'd1, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h03_00_03_00_55_FF_01, 7'b0001011, 1, "ovf_r3");
        drive(0, 7'h00, 2'd0, 1, 3'd3, 8'hFF, 7'h00, 7'h00, 56'h03_00_03_FF_55_FF_01, 7'b0001011, 0, "reload_r3");
        drive(1, 7'b0001000, 2'd1, 0, 3'd0, 8'h00, 7'h00, 7'b0001000, 56'h03_00_03_00_55_FF_01, 7'b0001011, 1, "set_beats_clr");
        drive(0, 7'h00, 2'd0, 0, 3'd0, 8'h00, 7'h00, 7'b0001000, 56'h03_00_03_00_55_FF_01, 7'b0000011, 0, "ovf_clr_r3");

        // Out-of-range load index and zero step.
        drive(0, 7'h00, 2'd0, 1, 3'd7, 8'h77, 7'h00, 7'h00, 56'h03_00_03_00_55_FF_01, 7'b0000011, 0, "ld_idx7");
        drive(1, 7'h7F, 2'd0, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h03_00_03_00_55_FF_01, 7'b0000011, 0, "step0");

        // Saturated reg1 stays pinned; simultaneous clear loses to the new overflow.
        drive(1, 7'b0000010, 2'd1, 0, 3'd0, 8'h00, 7'h00, 7'b0000010, 56'h03_00_03_00_55_FF_01, 7'b0000011, 1, "sat_hold");

        // Bulk clear leaves flags, then flags clear.
        drive(0, 7'h00, 2'd0, 0, 3'd0, 8'h00, 7'h7F, 7'h00, 56'h0, 7'b0000011, 0, "clr_all");
        drive(0, 7'h00, 2'd0, 0, 3'd0, 8'h00, 7'h00, 7'h7F, 56'h0, 7'h00, 0, "ovfclr_all");

        // Back-to-back increments keep the ack high.
        drive(1, 7'h7F, 2'd2, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h02_02_02_02_02_02_02, 7'h00, 1, "b2b1");
        drive(1, 7'h7F, 2'd2, 0, 3'd0, 8'h00, 7'h00, 7'h00, 56'h04_04_04_04_04_04_04, 7'h00, 1, "b2b2");
        idle(56'h04_04_04_04_04_04_04, 7'h00, "final_idle");

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        if (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
